// File: rtl/vlane_commit_ctrl.sv
// Vector-lane commit controller: in-order retire of multi-lane commands.
// Optional VLANE_COMMIT_BYPASS_EN lets this cycle's lane commits complete the head.
module vlane_commit_ctrl #(
  parameter int NUM_LANE = 4,
  parameter int NUM_ENTRY_HAZARD = 8,
  localparam int WIDTH_ENTRY_HAZARD = $clog2(NUM_ENTRY_HAZARD)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   I_Issue,
  input  logic [WIDTH_ENTRY_HAZARD-1:0]          I_Issue_No,
  input  logic [NUM_LANE-1:0]                    I_En_Lane,
  input  logic [NUM_LANE-1:0]                    I_Commit_Lane,
  input  logic [NUM_LANE*WIDTH_ENTRY_HAZARD-1:0] I_Commit_No,
  output logic                                   O_Full,
  output logic                                   O_Empty,
  output logic                                   O_Commit,
  output logic [WIDTH_ENTRY_HAZARD-1:0]          O_Commit_No,
  output logic                                   O_Error
);

  localparam int N = NUM_ENTRY_HAZARD;
  localparam int W = WIDTH_ENTRY_HAZARD;
  localparam int L = NUM_LANE;

  typedef logic [W-1:0] issue_no_t;
  typedef logic [L-1:0] commit_lane_t;

  logic [N-1:0] v_q, v_d;
  issue_no_t    no_q [N];
  issue_no_t    no_d [N];
  commit_lane_t en_lane_q [N];
  commit_lane_t en_lane_d [N];
  commit_lane_t en_commit_q [N];
  commit_lane_t en_commit_d [N];
  issue_no_t    wptr_q, wptr_d;
  issue_no_t    rptr_q, rptr_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         commit_q, commit_d;
  issue_no_t    commit_no_q, commit_no_d;
  logic         err_q, err_d;

  logic         full;
  logic         accept;
  logic         head_done;
  logic         err_lane;
  logic         found;
  logic [W:0]   sum;
  issue_no_t    idx;
  commit_lane_t hit;
  commit_lane_t set_mask [N];

  assign full   = (cnt_q == (W+1)'(N));
  assign accept = I_Issue && !full;

  // Per lane: find the oldest valid entry waiting on that lane's issue_no.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) set_mask[i] = '0;
    for (int k = 0; k < L; k++) begin
      found = 1'b0;
      if (I_Commit_Lane[k]) begin
        for (int j = 0; j < N; j++) begin
          sum = {1'b0, rptr_q} + (W+1)'(j);
          if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
          idx = sum[W-1:0];
          if (!found && v_q[idx] &&
              no_q[idx] == I_Commit_No[k*W +: W] &&
              en_lane_q[idx][k]) begin
            found            = 1'b1;
            set_mask[idx][k] = 1'b1;
            hit[k]           = 1'b1;
          end
        end
      end
    end
  end

  assign err_lane = |(I_Commit_Lane & ~hit);

`ifdef VLANE_COMMIT_BYPASS_EN
  commit_lane_t head_hit;
  assign head_hit  = set_mask[rptr_q];
  assign head_done = v_q[rptr_q] &&
    ((en_commit_q[rptr_q] | head_hit) == en_lane_q[rptr_q]);
`else
  assign head_done = v_q[rptr_q] &&
    (en_commit_q[rptr_q] == en_lane_q[rptr_q]);
`endif

  // Next state: lane commit marks, head retire, tail issue, counters.
  always_comb begin
    v_d         = v_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    commit_d    = 1'b0;
    commit_no_d = commit_no_q;
    for (int i = 0; i < N; i++) begin
      no_d[i]        = no_q[i];
      en_lane_d[i]   = en_lane_q[i];
      en_commit_d[i] = en_commit_q[i] | set_mask[i];
    end
    if (head_done) begin
      v_d[rptr_q]         = 1'b0;
      en_commit_d[rptr_q] = '0;
      rptr_d      = (rptr_q == W'(N-1)) ? '0 : rptr_q + 1'b1;
      commit_d    = 1'b1;
      commit_no_d = no_q[rptr_q];
    end
    if (accept) begin
      v_d[wptr_q]         = 1'b1;
      no_d[wptr_q]        = I_Issue_No;
      en_lane_d[wptr_q]   = I_En_Lane;
      en_commit_d[wptr_q] = '0;
      wptr_d = (wptr_q == W'(N-1)) ? '0 : wptr_q + 1'b1;
    end
    cnt_d = cnt_q + (W+1)'(accept) - (W+1)'(head_done);
    err_d = err_q | (I_Issue && full) | err_lane;
  end

  // State registers, all cleared by async reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q         <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      commit_q    <= 1'b0;
      commit_no_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        no_q[i]        <= '0;
        en_lane_q[i]   <= '0;
        en_commit_q[i] <= '0;
      end
    end else begin
      v_q         <= v_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      commit_q    <= commit_d;
      commit_no_q <= commit_no_d;
      err_q       <= err_d;
      for (int i = 0; i < N; i++) begin
        no_q[i]        <= no_d[i];
        en_lane_q[i]   <= en_lane_d[i];
        en_commit_q[i] <= en_commit_d[i];
      end
    end
  end

  assign O_Full      = full;
  assign O_Empty     = (cnt_q == '0);
  assign O_Commit    = commit_q;
  assign O_Commit_No = commit_no_q;
  assign O_Error     = err_q;

endmodule
